spi_tx_queue: RTL and testbench

- Upstream feeder for the SPI master: buffers 32-bit command words from the processor side and presents them one at a time on ToSPI/enable.
- Uses the master's SPI_CS (active-low chip select) to detect frame start and frame end.
- Enforces a minimum inter-frame gap and a start timeout so a stalled master cannot hang the queue.

---
 rtl/spi_tx_queue.sv | 172 +++++++++++++++++
 tb/tb_spi_tx_queue.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_queue.sv
// Command-word FIFO feeding the SPI master: hands words over on ToSPI/enable one frame at a time,
// tracks the frame through SPI_CS and enforces an inter-frame gap and a start timeout.
module spi_tx_queue #(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned ADDR_W        = 2,
    parameter int unsigned GAP_CYCLES    = 8,
    parameter int unsigned START_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [31:0]       wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic [31:0]       ToSPI,
    output logic              enable,
    input  logic              SPI_CS,
    output logic              busy,
    output logic              overflow,
    output logic              timeout_err,
    output logic [7:0]        frames_done
);

    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned ToW  = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

    localparam logic [GapW-1:0]   GapLast   = GapW'(GAP_CYCLES - 1);
    localparam logic [GapW-1:0]   GapOne    = GapW'(1);
    localparam logic [ToW-1:0]    ToLast    = ToW'(START_TIMEOUT - 1);
    localparam logic [ToW-1:0]    ToOne     = ToW'(1);
    localparam logic [ADDR_W:0]   FullCount = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CountOne  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PtrOne    = ADDR_W'(1);

    typedef enum logic [1:0] {StIdle, StReq, StActive, StGap} state_e;

    state_e            state_q, state_d;
    logic [31:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       tospi_q, tospi_d;
    logic              enable_q, enable_d;
    logic              overflow_q, overflow_d;
    logic              timeout_q, timeout_d;
    logic [7:0]        frames_q, frames_d;
    logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [ToW-1:0]    to_cnt_q, to_cnt_d;
    logic              pop;
    logic              wr_accept;

    assign full        = (count_q == FullCount);
    assign empty       = (count_q == '0);
    assign count       = count_q;
    assign ToSPI       = tospi_q;
    assign enable      = enable_q;
    assign busy        = (state_q != StIdle);
    assign overflow    = overflow_q;
    assign timeout_err = timeout_q;
    assign frames_done = frames_q;

    // A pop in the same cycle frees a slot, so a write into a full queue still lands.
    assign pop       = (state_q == StIdle) && !empty;
    assign wr_accept = wr_en && (!full || pop);

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end else if (wr_en) begin
            overflow_d = 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end

        unique case ({wr_accept, pop})
            2'b10:   count_d = count_q + CountOne;
            2'b01:   count_d = count_q - CountOne;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        tospi_d   = tospi_q;
        enable_d  = 1'b0;
        timeout_d = timeout_q;
        frames_d  = frames_q;
        gap_cnt_d = gap_cnt_q;
        to_cnt_d  = to_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    tospi_d  = mem_q[rd_ptr_q];
                    enable_d = 1'b1;
                    to_cnt_d = '0;
                    state_d  = StReq;
                end
            end
            StReq: begin
                // CS falling takes priority over an expiring timeout.
                if (!SPI_CS) begin
                    state_d = StActive;
                end else if (to_cnt_q == ToLast) begin
                    timeout_d = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = StGap;
                end else begin
                    enable_d = 1'b1;
                    to_cnt_d = to_cnt_q + ToOne;
                end
            end
            StActive: begin
                if (SPI_CS) begin
                    frames_d  = frames_q + 8'd1;
                    gap_cnt_d = '0;
                    state_d   = StGap;
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + GapOne;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            tospi_q    <= '0;
            enable_q   <= 1'b0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
            frames_q   <= '0;
            gap_cnt_q  <= '0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            tospi_q    <= tospi_d;
            enable_q   <= enable_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
            frames_q   <= frames_d;
            gap_cnt_q  <= gap_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    // Storage needs no reset: count and pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (!reset && wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_spi_tx_queue.sv
// Bench for spi_tx_queue: directed stimulus, a scoreboard of words expected on each enable
// rise, a small SPI master model driving SPI_CS, and directed status checks.
module tb_spi_tx_queue;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic [31:0] ToSPI;
    logic        enable;
    logic        spi_cs;
    logic        busy;
    logic        overflow;
    logic        timeout_err;
    logic [7:0]  frames_done;

    bit   cs_auto;
    logic cs_man;
    logic cs_model;
    int   cs_delay;
    int   cs_len;

    int n_run;
    int n_fail;
    logic [31:0] exp_q[$];
    logic prev_en;

    assign spi_cs = cs_auto ? cs_model : cs_man;

    spi_tx_queue #(
        .DEPTH         (4),
        .ADDR_W        (2),
        .GAP_CYCLES    (8),
        .START_TIMEOUT (64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .ToSPI       (ToSPI),
        .enable      (enable),
        .SPI_CS      (spi_cs),
        .busy        (busy),
        .overflow    (overflow),
        .timeout_err (timeout_err),
        .frames_done (frames_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_word(input logic [31:0] d, input bit accepted);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        if (accepted) exp_q.push_back(d);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || !empty) && n < budget) begin
            tick();
            n++;
        end
        n_run++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL %s: still busy after %0d cycles, %0d words outstanding, expected drained",
                     name, n, exp_q.size());
        end
    endtask

    // SPI master model: answers each enable with CS low after cs_delay cycles for cs_len cycles.
    initial begin
        cs_model = 1'b1;
        forever begin
            @(negedge clk);
            if (cs_auto && enable === 1'b1) begin
                repeat (cs_delay) @(negedge clk);
                cs_model = 1'b0;
                repeat (cs_len) @(negedge clk);
                cs_model = 1'b1;
            end
        end
    end

    // Scoreboard monitor: every enable rise must present the next expected word.
    initial begin
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (enable === 1'b1 && prev_en !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_run++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got word %h expected no frame", ToSPI);
                end else begin
                    check("sb_tospi", ToSPI, exp_q.pop_front());
                end
            end
            prev_en = enable;
        end
    end

    initial begin
        int n;
        n_run    = 0;
        n_fail   = 0;
        reset    = 1'b1;
        wr_en    = 1'b0;
        wr_data  = '0;
        cs_man   = 1'b1;
        cs_auto  = 1'b0;
        cs_delay = 2;
        cs_len   = 3;
        repeat (3) tick();
        reset = 1'b0;

        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_enable", 32'(enable), 32'd0);
        check("rst_tospi", ToSPI, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flags", {30'd0, overflow, timeout_err}, 32'd0);
        check("rst_frames", 32'(frames_done), 32'd0);

        // Reset in the middle of an active frame with three words queued.
        put_word(32'h1111_0000, 1'b1);
        put_word(32'h1111_0001, 1'b1);
        put_word(32'h1111_0002, 1'b1);
        put_word(32'h1111_0003, 1'b1);
        check("midrst_count_pre", 32'(count), 32'd3);
        check("midrst_en_pre", 32'(enable), 32'd1);
        cs_man = 1'b0;
        tick();
        check("midrst_active_en", 32'(enable), 32'd0);
        check("midrst_active_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        cs_man = 1'b1;
        exp_q.delete();
        check("midrst_en", 32'(enable), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_frames", 32'(frames_done), 32'd0);

        // Single frame latency and the inter-frame gap.
        put_word(32'hB38F0F82, 1'b1);
        check("lat_count_k", 32'(count), 32'd1);
        check("lat_en_k", 32'(enable), 32'd0);
        tick();
        check("lat_en_k1", 32'(enable), 32'd1);
        check("lat_tospi_k1", ToSPI, 32'hB38F0F82);
        check("lat_count_k1", 32'(count), 32'd0);
        repeat (4) tick();
        cs_man = 1'b0;
        tick();
        check("cs_low_en", 32'(enable), 32'd0);
        check("cs_low_busy", 32'(busy), 32'd1);
        repeat (34) tick();
        cs_man = 1'b1;
        tick();
        check("frame_done_1", 32'(frames_done), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check("gap_en_low", 32'(enable), 32'd0);
            check("gap_busy", 32'(busy), 32'd1);
            tick();
        end
        check("gap_end_idle", 32'(busy), 32'd0);

        // Overflow while the master stalls in the request phase.
        put_word(32'hA0A0_A0A0, 1'b1);
        put_word(32'hA1A1_A1A1, 1'b1);
        put_word(32'hA2A2_A2A2, 1'b1);
        put_word(32'hA3A3_A3A3, 1'b1);
        put_word(32'hA4A4_A4A4, 1'b1);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_count4", 32'(count), 32'd4);
        check("ovf_flag_pre", 32'(overflow), 32'd0);
        put_word(32'hA5A5_A5A5, 1'b0);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_count_hold", 32'(count), 32'd4);

        // Write into a full queue in the same cycle as the idle pop.
        cs_auto = 1'b1;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check("popwr_idle_full", 32'(full), 32'd1);
        put_word(32'hB0B0_B0B0, 1'b1);
        check("popwr_count", 32'(count), 32'd4);
        check("popwr_en", 32'(enable), 32'd1);
        drain("drain_ovf", 500);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Start timeout with CS held high.
        cs_auto = 1'b0;
        cs_man  = 1'b1;
        put_word(32'h7777_0000, 1'b1);
        check("to_count_k", 32'(count), 32'd1);
        tick();
        check("to_en_rise", 32'(enable), 32'd1);
        check("to_count_pop", 32'(count), 32'd0);
        put_word(32'h7777_0001, 1'b1);
        repeat (62) tick();
        check("to_en_last", 32'(enable), 32'd1);
        check("to_err_pre", 32'(timeout_err), 32'd0);
        tick();
        check("to_en_drop", 32'(enable), 32'd0);
        check("to_err", 32'(timeout_err), 32'd1);
        check("to_count_after", 32'(count), 32'd1);
        check("to_busy_gap", 32'(busy), 32'd1);
        repeat (8) tick();
        check("to_gap_en", 32'(enable), 32'd0);
        check("to_gap_idle", 32'(busy), 32'd0);
        tick();
        check("to_next_req", 32'(enable), 32'd1);
        cs_auto = 1'b1;
        drain("drain_to", 500);

        // 256 frames wrap the frame counter with no errors.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("wrap_rst_frames", 32'(frames_done), 32'd0);
        for (int i = 0; i < 256; i++) begin
            n = 0;
            while (full && n < 100) begin
                tick();
                n++;
            end
            put_word(32'hC000_0000 | 32'(i), 1'b1);
            if (i == 0) check("wrap_first_count", 32'(count), 32'd1);
        end
        drain("drain_wrap", 20000);
        check("wrap_frames", 32'(frames_done), 32'd0);
        check("wrap_overflow", 32'(overflow), 32'd0);
        check("wrap_timeout", 32'(timeout_err), 32'd0);
        check("wrap_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
